// File: rtl/delay_sequencer_if.sv
// Control/status bundle between a delay sequencer and the block that commands it.
// The master issues delay requests; the slave (the sequencer) reports progress.
interface delay_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             repeat_en;
  logic [CNT_W-1:0] delay_ms;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] elapsed;

  modport master (
    output start, abort, repeat_en, delay_ms,
    input  busy, done, aborted, elapsed
  );

  modport slave (
    input  start, abort, repeat_en, delay_ms,
    output busy, done, aborted, elapsed
  );
endinterface

// File: rtl/delay_sequencer.sv
// Counts 1 ms ticks from an external millisecond timer up to a requested delay,
// in one-shot or periodic mode, with abort and registered status outputs.
module delay_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  delay_sequencer_if.slave  ctrl,
  input  logic              timer_tick,
  output logic              timer_en
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] target, target_next;
  logic [CNT_W-1:0] elapsed_q, elapsed_next;
  logic [CNT_W-1:0] elapsed_inc;
  logic             rpt, rpt_next;
  logic             tick_prev, tick_prev_next;
  logic             busy_q, busy_next;
  logic             timer_en_q, timer_en_next;
  logic             done_q, done_next;
  logic             aborted_q, aborted_next;
  logic             tick_edge;
  logic             terminal;

  assign tick_edge   = timer_tick & ~tick_prev;
  assign elapsed_inc = elapsed_q + 1'b1;
  assign terminal    = tick_edge && (elapsed_inc == target);

  // All state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      target     <= '0;
      elapsed_q  <= '0;
      rpt        <= 1'b0;
      tick_prev  <= 1'b0;
      busy_q     <= 1'b0;
      timer_en_q <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state      <= state_next;
      target     <= target_next;
      elapsed_q  <= elapsed_next;
      rpt        <= rpt_next;
      tick_prev  <= tick_prev_next;
      busy_q     <= busy_next;
      timer_en_q <= timer_en_next;
      done_q     <= done_next;
      aborted_q  <= aborted_next;
    end
  end

  // Abort outranks a terminal tick arriving in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ctrl.start && (ctrl.delay_ms != '0)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (ctrl.abort) begin
          state_next = IDLE;
        end else if (terminal && !rpt) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the datapath and of the registered outputs.
  always_comb begin
    target_next    = target;
    elapsed_next   = elapsed_q;
    rpt_next       = rpt;
    tick_prev_next = 1'b0;
    busy_next      = 1'b0;
    timer_en_next  = 1'b0;
    done_next      = 1'b0;
    aborted_next   = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl.start) begin
          elapsed_next = '0;
          if (ctrl.delay_ms == '0) begin
            done_next = 1'b1;
          end else begin
            target_next   = ctrl.delay_ms;
            rpt_next      = ctrl.repeat_en;
            busy_next     = 1'b1;
            timer_en_next = 1'b1;
          end
        end
      end
      RUN: begin
        tick_prev_next = timer_tick;
        if (ctrl.abort) begin
          aborted_next = 1'b1;
        end else if (terminal) begin
          done_next = 1'b1;
          if (rpt) begin
            elapsed_next  = '0;
            busy_next     = 1'b1;
            timer_en_next = 1'b1;
          end else begin
            elapsed_next = target;
          end
        end else begin
          if (tick_edge) begin
            elapsed_next = elapsed_inc;
          end
          busy_next     = 1'b1;
          timer_en_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ctrl.busy    = busy_q;
  assign ctrl.done    = done_q;
  assign ctrl.aborted = aborted_q;
  assign ctrl.elapsed = elapsed_q;
  assign timer_en     = timer_en_q;

endmodule

// File: tb/tb_delay_sequencer.sv
// Randomized scoreboard bench for delay_sequencer: jobs are described at the
// transaction level and the expected done/aborted events are queued up front.
module tb_delay_sequencer;

  localparam int CNT_W = 16;

  typedef struct {
    bit               is_abort;
    logic [CNT_W-1:0] el;
  } ev_t;

  logic clk;
  logic reset;
  logic timer_tick;
  logic timer_en;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  ev;

  delay_sequencer_if #(.CNT_W(CNT_W)) ctrl ();

  delay_sequencer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl       (ctrl),
    .timer_tick (timer_tick),
    .timer_en   (timer_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every done/aborted pulse must match the oldest queued event.
  always @(negedge clk) begin
    if (ctrl.done || ctrl.aborted) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: got done=%0b aborted=%0b expected no pulse at %0t",
                 ctrl.done, ctrl.aborted, $time);
      end else begin
        ev = exp_q.pop_front();
        if ((ctrl.done !== !ev.is_abort) || (ctrl.aborted !== ev.is_abort) ||
            (ctrl.elapsed !== ev.el)) begin
          errors++;
          $display("[TB] FAIL pulse_event: got done=%0b aborted=%0b elapsed=%0d expected done=%0b aborted=%0b elapsed=%0d at %0t",
                   ctrl.done, ctrl.aborted, ctrl.elapsed, !ev.is_abort, ev.is_abort, ev.el, $time);
        end
      end
    end
  end

  task automatic push_ev(input bit is_abort, input int el);
    ev_t e;
    e.is_abort = is_abort;
    e.el       = CNT_W'(el);
    exp_q.push_back(e);
  endtask

  task automatic tick_once(input int hold, input int gap, input bit with_abort,
                           output logic busy_s, output logic en_s);
    timer_tick = 1'b1;
    if (with_abort) ctrl.abort = 1'b1;
    @(negedge clk);
    busy_s     = ctrl.busy;
    en_s       = timer_en;
    ctrl.abort = 1'b0;
    for (int j = 1; j < hold; j++) @(negedge clk);
    timer_tick = 1'b0;
    for (int j = 0; j < gap; j++) @(negedge clk);
  endtask

  // mode 0: run to completion, 1: abort after k ticks, 2: abort on the k-th tick
  task automatic run_job(input int d, input bit r, input int k, input int mode,
                         input int hold, input int gap);
    int   counted;
    int   c;
    int   h;
    logic busy_s, en_s;
    bit   last;

    counted = (mode == 2) ? k - 1 : k;
    if (d == 0) begin
      push_ev(1'b0, 0);
    end else if (!r) begin
      if (mode == 0) push_ev(1'b0, d);
      else           push_ev(1'b1, counted);
    end else begin
      for (int i = 0; i < counted / d; i++) push_ev(1'b0, 0);
      if (mode != 0) push_ev(1'b1, counted % d);
    end

    ctrl.start     = 1'b1;
    ctrl.delay_ms  = CNT_W'(d);
    ctrl.repeat_en = r;
    @(negedge clk);
    ctrl.start     = 1'b0;
    ctrl.delay_ms  = CNT_W'($urandom);
    ctrl.repeat_en = $urandom_range(0, 1);

    if (d == 0) begin
      check_value("zero_busy", ctrl.busy, 0);
      check_value("zero_timer_en", timer_en, 0);
      @(negedge clk);
      check_value("zero_busy_after", ctrl.busy, 0);
      check_value("zero_timer_en_after", timer_en, 0);
      return;
    end

    check_value("start_busy", ctrl.busy, 1);
    check_value("start_timer_en", timer_en, 1);
    check_value("start_elapsed", ctrl.elapsed, 0);

    c = 0;
    for (int i = 1; i <= k; i++) begin
      if (i == 1) begin
        ctrl.start     = 1'b1;
        ctrl.delay_ms  = CNT_W'(d + 7);
        ctrl.repeat_en = ~r;
        @(negedge clk);
        ctrl.start = 1'b0;
        check_value("start_in_run_busy", ctrl.busy, 1);
      end
      last = (i == k);
      h    = (hold > 0) ? hold : $urandom_range(1, 3);
      tick_once(h, gap, (mode == 2) && last, busy_s, en_s);
      if (!((mode == 2) && last)) c++;
      check_value("elapsed_after_tick", ctrl.elapsed, r ? c % d : c);
      if (last && (mode == 2 || (mode == 0 && !r))) begin
        check_value("end_busy", busy_s, 0);
        check_value("end_timer_en", en_s, 0);
      end else begin
        check_value("run_busy", busy_s, 1);
        check_value("run_timer_en", en_s, 1);
      end
    end

    if (mode == 1) begin
      ctrl.abort = 1'b1;
      @(negedge clk);
      ctrl.abort = 1'b0;
      check_value("abort_busy", ctrl.busy, 0);
      check_value("abort_timer_en", timer_en, 0);
      check_value("abort_elapsed", ctrl.elapsed, r ? c % d : c);
    end

    ctrl.abort = 1'b1;
    @(negedge clk);
    ctrl.abort = 1'b0;
    check_value("idle_abort_busy", ctrl.busy, 0);
    @(negedge clk);
  endtask

  task automatic reset_mid_run();
    logic busy_s, en_s;
    ctrl.start     = 1'b1;
    ctrl.delay_ms  = CNT_W'(9);
    ctrl.repeat_en = 1'b0;
    @(negedge clk);
    ctrl.start = 1'b0;
    for (int i = 0; i < 3; i++) tick_once(1, 2, 1'b0, busy_s, en_s);
    check_value("pre_reset_elapsed", ctrl.elapsed, 3);
    #2 reset = 1'b0;
    #1;
    check_value("reset_busy", ctrl.busy, 0);
    check_value("reset_timer_en", timer_en, 0);
    check_value("reset_done", ctrl.done, 0);
    check_value("reset_aborted", ctrl.aborted, 0);
    check_value("reset_elapsed", ctrl.elapsed, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick_once(1, 2, 1'b0, busy_s, en_s);
    check_value("post_reset_busy", ctrl.busy, 0);
    check_value("post_reset_elapsed", ctrl.elapsed, 0);
  endtask

  initial begin
    int d, k, kind;
    bit r;
    reset          = 1'b0;
    timer_tick     = 1'b0;
    ctrl.start     = 1'b0;
    ctrl.abort     = 1'b0;
    ctrl.repeat_en = 1'b0;
    ctrl.delay_ms  = '0;
    #1;
    check_value("rst_busy", ctrl.busy, 0);
    check_value("rst_timer_en", timer_en, 0);
    check_value("rst_done", ctrl.done, 0);
    check_value("rst_aborted", ctrl.aborted, 0);
    check_value("rst_elapsed", ctrl.elapsed, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_job(3, 1'b0, 3, 0, 1, 9);
    run_job(0, 1'b0, 0, 0, 1, 1);
    run_job(2, 1'b1, 6, 1, 1, 3);
    run_job(2, 1'b0, 2, 2, 1, 3);
    run_job(4, 1'b0, 4, 0, 5, 2);
    run_job(3, 1'b1, 5, 2, 5, 1);
    reset_mid_run();

    for (int n = 0; n < 30; n++) begin
      d    = $urandom_range(0, 5);
      r    = $urandom_range(0, 1);
      kind = $urandom_range(0, 2);
      if (d == 0) begin
        run_job(0, r, 0, 0, 1, 1);
      end else if (!r) begin
        if (kind == 0)      run_job(d, 1'b0, d, 0, 0, $urandom_range(1, 4));
        else if (kind == 1) run_job(d, 1'b0, $urandom_range(0, d - 1), 1, 0, $urandom_range(1, 4));
        else                run_job(d, 1'b0, $urandom_range(1, d), 2, 0, $urandom_range(1, 4));
      end else begin
        k = (kind == 2) ? $urandom_range(1, 3 * d) : $urandom_range(0, 3 * d);
        run_job(d, 1'b1, k, (kind == 2) ? 2 : 1, 0, $urandom_range(1, 4));
      end
    end

    repeat (3) @(negedge clk);
    check_value("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
